// File: rtl/adpcm_word_packer_if.sv
// Valid/ready bundle between the ADPCM code source, the word packer and the word consumer.
// master drives capture control and consumer ready; slave is the packer.
interface adpcm_word_packer_if #(
   parameter int unsigned FIFO_DEPTH = 8
);
   localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

   logic              enable;
   logic              in_strobe;
   logic [3:0]        in_code;
   logic              out_ready;
   logic              out_valid;
   logic [15:0]       out_data;
   logic [2:0]        out_nvalid;
   logic              out_last;
   logic              overflow;
   logic [LevelW-1:0] fifo_level;

   modport master (
      output enable, in_strobe, in_code, out_ready,
      input  out_valid, out_data, out_nvalid, out_last, overflow, fifo_level
   );

   modport slave (
      input  enable, in_strobe, in_code, out_ready,
      output out_valid, out_data, out_nvalid, out_last, overflow, fifo_level
   );
endinterface

// File: rtl/adpcm_word_packer.sv
// Packs 4-bit ADPCM codes MSB-nibble-first into 16-bit words and queues them in a FWFT FIFO.
// End of capture pushes a partial word or a zero-nibble terminator, both flagged last.
module adpcm_word_packer #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic                clk,
   input logic                rst,
   adpcm_word_packer_if.slave bus
);
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned LevelW = AW + 1;
   localparam logic [AW:0] PtrOne = 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

   state_e      state_q, state_d;
   logic [1:0]  count_q, count_d;
   logic [15:0] word_q, word_d, word_ins;
   logic        push_q, push_d;
   logic [19:0] entry_q, entry_d;
   logic        overflow_q, ovf_clr;

   logic [19:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [LevelW-1:0] level;
   logic        full, empty, pop, wr_en, drop;
   logic [19:0] head;

   always_comb begin
      word_ins = word_q;
      unique case (count_q)
         2'd0: word_ins[15:12] = bus.in_code;
         2'd1: word_ins[11:8]  = bus.in_code;
         2'd2: word_ins[7:4]   = bus.in_code;
         2'd3: word_ins[3:0]   = bus.in_code;
         default: word_ins = word_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      word_d  = word_q;
      push_d  = 1'b0;
      entry_d = entry_q;
      ovf_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.enable) begin
               state_d = StRun;
               count_d = 2'd0;
               word_d  = 16'h0000;
               ovf_clr = 1'b1;
            end
         end
         StRun: begin
            if (!bus.enable) begin
               state_d = StFlush;
            end else if (bus.in_strobe) begin
               if (count_q == 2'd3) begin
                  push_d  = 1'b1;
                  entry_d = {word_ins, 3'd4, 1'b0};
                  count_d = 2'd0;
                  word_d  = 16'h0000;
               end else begin
                  count_d = count_q + 2'd1;
                  word_d  = word_ins;
               end
            end
         end
         StFlush: begin
            // With count 0 the cleared word register already forms the terminator.
            push_d  = 1'b1;
            entry_d = {word_q, 1'b0, count_q, 1'b1};
            count_d = 2'd0;
            word_d  = 16'h0000;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= 2'd0;
         word_q  <= 16'h0000;
         push_q  <= 1'b0;
         entry_q <= 20'h00000;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         word_q  <= word_d;
         push_q  <= push_d;
         entry_q <= entry_d;
      end
   end

   assign level = LevelW'(wr_ptr_q - rd_ptr_q);
   assign full  = (level == LevelW'(FIFO_DEPTH));
   assign empty = (level == '0);
   assign pop   = !empty && bus.out_ready;
   // A full FIFO still accepts the staged word when the head leaves in the same cycle.
   assign wr_en = push_q && (!full || pop);
   assign drop  = push_q && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= entry_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)   rd_ptr_q <= rd_ptr_q + PtrOne;
         if (drop)         overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   assign head           = mem[rd_ptr_q[AW-1:0]];
   assign bus.out_valid  = !empty;
   assign bus.out_data   = empty ? 16'h0000 : head[19:4];
   assign bus.out_nvalid = empty ? 3'd0 : head[3:1];
   assign bus.out_last   = empty ? 1'b0 : head[0];
   assign bus.overflow   = overflow_q;
   assign bus.fifo_level = level;
endmodule

// File: tb/tb_adpcm_word_packer.sv
// Directed bench for adpcm_word_packer: expected words are queued as codes are driven and
// compared whenever the packer hands a word to the consumer.
module tb_adpcm_word_packer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [19:0] sb [$];

   adpcm_word_packer_if #(.FIFO_DEPTH(8)) bus ();

   adpcm_word_packer #(.FIFO_DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [3:0] code);
      bus.in_strobe = 1'b1;
      bus.in_code   = code;
      tick();
      bus.in_strobe = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t = 0;
      bus.out_ready = 1'b1;
      while ((sb.size() != 0 || bus.out_valid) && t < 100) begin
         tick();
         t++;
      end
      check({tag, "_drained"}, 32'(sb.size()), 32'd0);
      check({tag, "_level0"}, 32'(bus.fifo_level), 32'd0);
   endtask

   // Scoreboard: every accepted word must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $error("FAIL unexpected_word: observed %0h expected none",
                   {bus.out_data, bus.out_nvalid, bus.out_last});
         end else begin
            logic [19:0] exp;
            exp = sb.pop_front();
            assert ({bus.out_data, bus.out_nvalid, bus.out_last} === exp) else begin
               n_err++;
               $error("FAIL word: observed %0h expected %0h",
                      {bus.out_data, bus.out_nvalid, bus.out_last}, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.enable    = 1'b0;
      bus.in_strobe = 1'b0;
      bus.in_code   = 4'h0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_nvalid", 32'(bus.out_nvalid), 32'd0);
      check("rst_last", 32'(bus.out_last), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_level", 32'(bus.fifo_level), 32'd0);
      rst = 1'b0;
      tick();

      // Strobes in IDLE are ignored.
      strobe(4'h9);
      strobe(4'h8);
      tick();
      tick();
      check("idle_ignore", 32'(bus.fifo_level), 32'd0);

      // 1) Full word, latency of the registered push.
      bus.out_ready = 1'b1;
      bus.enable    = 1'b1;
      tick();
      sb.push_back({16'h1234, 3'd4, 1'b0});
      strobe(4'h1);
      strobe(4'h2);
      strobe(4'h3);
      strobe(4'h4);
      check("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t1_valid", 32'(bus.out_valid), 32'd1);
      check("t1_level", 32'(bus.fifo_level), 32'd1);
      drain("t1");

      // 2) Partial word on capture end.
      strobe(4'hA);
      strobe(4'hB);
      sb.push_back({16'hAB00, 3'd2, 1'b1});
      bus.enable = 1'b0;
      tick();
      tick();
      drain("t2");

      // 3) Full word followed by terminator.
      bus.enable = 1'b1;
      tick();
      sb.push_back({16'h5678, 3'd4, 1'b0});
      strobe(4'h5);
      strobe(4'h6);
      strobe(4'h7);
      strobe(4'h8);
      sb.push_back({16'h0000, 3'd0, 1'b1});
      bus.enable = 1'b0;
      tick();
      tick();
      drain("t3");

      // 4) Fill past capacity with the consumer stalled.
      bus.out_ready = 1'b0;
      bus.enable    = 1'b1;
      tick();
      for (int w = 0; w < 9; w++) begin
         logic [15:0] word;
         for (int k = 0; k < 4; k++) word[15-4*k -: 4] = 4'((4 * w + k + 1) % 16);
         if (w < 8) sb.push_back({word, 3'd4, 1'b0});
         for (int k = 0; k < 4; k++) strobe(4'((4 * w + k + 1) % 16));
      end
      tick();
      tick();
      check("t4_level", 32'(bus.fifo_level), 32'd8);
      check("t4_overflow", 32'(bus.overflow), 32'd1);
      check("t4_head", 32'(bus.out_data), 32'h1234);
      bus.enable = 1'b0;
      tick();
      tick();
      tick();
      check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);
      check("t4_head_stable", 32'(bus.out_data), 32'h1234);
      bus.enable = 1'b1;
      tick();
      tick();
      check("t4_ovf_cleared", 32'(bus.overflow), 32'd0);

      // 5) Full FIFO, push and pop on the same edge.
      sb.push_back({16'h9ABC, 3'd4, 1'b0});
      strobe(4'h9);
      strobe(4'hA);
      strobe(4'hB);
      strobe(4'hC);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("t5_level", 32'(bus.fifo_level), 32'd8);
      check("t5_overflow", 32'(bus.overflow), 32'd0);
      check("t5_head", 32'(bus.out_data), 32'h5678);
      sb.push_back({16'h0000, 3'd0, 1'b1});
      bus.enable = 1'b0;
      drain("t5");

      // 6) Asynchronous reset mid-capture with a word still queued.
      bus.out_ready = 1'b0;
      bus.enable    = 1'b1;
      tick();
      strobe(4'hD);
      strobe(4'hE);
      strobe(4'hF);
      strobe(4'h1);
      tick();
      check("t6_level_pre", 32'(bus.fifo_level), 32'd1);
      strobe(4'h1);
      strobe(4'h2);
      strobe(4'h3);
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t6_rst_level", 32'(bus.fifo_level), 32'd0);
      check("t6_rst_data", 32'(bus.out_data), 32'd0);
      check("t6_rst_overflow", 32'(bus.overflow), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      sb.push_back({16'h4567, 3'd4, 1'b0});
      strobe(4'h4);
      strobe(4'h5);
      strobe(4'h6);
      strobe(4'h7);
      sb.push_back({16'h0000, 3'd0, 1'b1});
      bus.enable = 1'b0;
      drain("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
